// File: rtl/shift_register.sv
// shift_register: WIDTH-bit parallel-load, rotate-right register.
// Each rising Clk edge applies one of three actions, in priority order:
// synchronous clear (ResetB high), parallel load (Load high), or a
// one-position circular rotate right. Q is taken straight from the register.
module shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             ResetB,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rot_next;

  // Rotate-right wiring: every bit takes its upper neighbour and the MSB
  // wraps around from the LSB, so no bit is ever dropped.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      if (gi == WIDTH - 1) begin : g_wrap
        assign rot_next[gi] = q_reg[0];
      end else begin : g_pass
        assign rot_next[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Next-state select: a load takes precedence over rotation.
  always_comb begin
    q_next = q_reg;
    if (Load) begin
      q_next = D;
    end else begin
      q_next = rot_next;
    end
  end

  // State register: the clear has the highest priority and overrides any load.
  always_ff @(posedge Clk) begin
    if (ResetB) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q = q_reg;

endmodule

// File: tb/tb_shift_register.sv
// Directed testbench for shift_register (WIDTH = 4).
// Inputs are driven on the falling edge and Q is sampled on the falling edge
// that follows each rising edge, so all observations lie between active edges.
module tb_shift_register;

  logic       Clk;
  logic       ResetB;
  logic       Load;
  logic [3:0] D;
  logic [3:0] Q;

  int total;
  int bad;

  shift_register #(.WIDTH(4)) dut (
    .Clk    (Clk),
    .ResetB (ResetB),
    .Load   (Load),
    .D      (D),
    .Q      (Q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and return on the following falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    // Get into a known non-zero state first: reset, then load 1011.
    ResetB = 1'b1; Load = 1'b0; D = 4'b0000;
    step();
    ResetB = 1'b0; Load = 1'b1; D = 4'b1011;
    step();
    total++;
    $display("reset_pre_load: Q=%b exp=%b", Q, 4'b1011);
    if (Q !== 4'b1011) begin
      bad++;
      $display("FAIL reset_pre_load: Q=%b expected %b", Q, 4'b1011);
    end
    // Reset together with a load: the clear must win.
    ResetB = 1'b1; Load = 1'b1; D = 4'b0110;
    step();
    total++;
    $display("reset_over_load: Q=%b exp=%b", Q, 4'b0000);
    if (Q !== 4'b0000) begin
      bad++;
      $display("FAIL reset_over_load: Q=%b expected %b", Q, 4'b0000);
    end
  endtask

  task automatic test_load();
    ResetB = 1'b0; Load = 1'b1; D = 4'b1001;
    step();
    total++;
    $display("load_1001: Q=%b exp=%b", Q, 4'b1001);
    if (Q !== 4'b1001) begin
      bad++;
      $display("FAIL load_1001: Q=%b expected %b", Q, 4'b1001);
    end
    // Toggle D between edges: Q must hold until the next rising edge.
    D = 4'b0110;
    #2;
    D = 4'b1111;
    #1;
    total++;
    $display("load_hold_between_edges: Q=%b exp=%b", Q, 4'b1001);
    if (Q !== 4'b1001) begin
      bad++;
      $display("FAIL load_hold_between_edges: Q=%b expected %b", Q, 4'b1001);
    end
    @(negedge Clk);
  endtask

  task automatic test_rotate();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0001;
    ResetB = 1'b0; Load = 1'b1; D = 4'b0001;
    step();
    Load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      $display("rotate_0001[%0d]: Q=%b exp=%b", i, Q, exp_seq[i]);
      if (Q !== exp_seq[i]) begin
        bad++;
        $display("FAIL rotate_0001[%0d]: Q=%b expected %b", i, Q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rotate_mixed();
    logic [3:0] exp_seq [2];
    exp_seq[0] = 4'b1110;
    exp_seq[1] = 4'b0111;
    ResetB = 1'b0; Load = 1'b1; D = 4'b1101;
    step();
    Load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      $display("rotate_1101[%0d]: Q=%b exp=%b", i, Q, exp_seq[i]);
      if (Q !== exp_seq[i]) begin
        bad++;
        $display("FAIL rotate_1101[%0d]: Q=%b expected %b", i, Q, exp_seq[i]);
      end
      total++;
      $display("popcount_1101[%0d]: ones=%0d exp=3", i, $countones(Q));
      if ($countones(Q) != 3) begin
        bad++;
        $display("FAIL popcount_1101[%0d]: ones=%0d expected 3", i, $countones(Q));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vec [3];
    vec[0] = 4'b0011;
    vec[1] = 4'b0100;
    vec[2] = 4'b0101;
    ResetB = 1'b0; Load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = vec[i];
      step();
      total++;
      $display("back_to_back[%0d]: Q=%b exp=%b", i, Q, vec[i]);
      if (Q !== vec[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: Q=%b expected %b", i, Q, vec[i]);
      end
    end
    Load = 1'b0;
  endtask

  task automatic test_reset_mid();
    ResetB = 1'b0; Load = 1'b1; D = 4'b1010;
    step();
    Load = 1'b0;
    step();
    total++;
    $display("mid_rotate: Q=%b exp=%b", Q, 4'b0101);
    if (Q !== 4'b0101) begin
      bad++;
      $display("FAIL mid_rotate: Q=%b expected %b", Q, 4'b0101);
    end
    ResetB = 1'b1;
    step();
    total++;
    $display("mid_reset: Q=%b exp=%b", Q, 4'b0000);
    if (Q !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset: Q=%b expected %b", Q, 4'b0000);
    end
    ResetB = 1'b0; Load = 1'b0;
    step();
    total++;
    $display("release_rotate_zero: Q=%b exp=%b", Q, 4'b0000);
    if (Q !== 4'b0000) begin
      bad++;
      $display("FAIL release_rotate_zero: Q=%b expected %b", Q, 4'b0000);
    end
    Load = 1'b1; D = 4'b1111;
    step();
    total++;
    $display("load_after_reset: Q=%b exp=%b", Q, 4'b1111);
    if (Q !== 4'b1111) begin
      bad++;
      $display("FAIL load_after_reset: Q=%b expected %b", Q, 4'b1111);
    end
    Load = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ResetB = 1'b1;
    Load   = 1'b0;
    D      = 4'b0000;
    @(negedge Clk);
    test_reset();
    test_load();
    test_rotate();
    test_rotate_mixed();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
4-bit parallel-load, rotate-right shift register. Single clock domain; synchronous reset, then parallel load, then rotation on every rising clock edge. Used as a small datapath/storage element. Q is driven directly from the internal register.

Parameters:
WIDTH, 4, register width in bits. D and Q are both WIDTH bits. Directed tests use the default.

Ports:
Clk  input  1  system clock; all state changes on the rising edge only
ResetB  input  1  synchronous reset, active-high; takes effect at the rising Clk edge while ResetB=1
Load  input  1  parallel-load enable, active-high, sampled at the rising Clk edge
D  input  WIDTH  parallel load data, sampled at the rising Clk edge when Load=1
Q  output  WIDTH  register contents (registered output, no combinational path from any input)

Behaviour:
- Interface fixed: one clock (Clk); reset (ResetB) is synchronous and active-high. The port name is kept as ResetB; the polarity is high-true.
- Priority at each rising Clk edge, highest first:
  1. ResetB=1: Q <= 0.
  2. Load=1: Q <= D.
  3. Otherwise rotate right by one: Q[WIDTH-1] <= Q[0] and Q[i] <= Q[i+1] for i = 0..WIDTH-2.
- Between edges, Q holds its value. Changes on ResetB, Load or D between edges have no effect until the next rising edge.
- Reset value: Q = 0. A rotate of 0 stays 0, so after reset Q holds 0 until the first load.
- Latency: one cycle. Q reflects a load or rotate after the edge that samples it.
- Rotation is circular:
  - no bits are lost;
  - the pattern repeats every WIDTH clocks with no load;
  - the popcount of Q is invariant under rotation.
- Simultaneous events:
  - ResetB=1 with Load=1: reset wins, Q=0.
  - Load=1 on consecutive edges: Q follows D each cycle and never rotates.
- Reset mid-operation: ResetB=1 at any edge clears Q on that edge, regardless of prior contents or load.
- Release from reset: the first edge with ResetB=0 performs a load or rotate per Load.
- Power-up before the first reset: Q is undefined. Verification starts only after one reset edge.
- No asynchronous behaviour; the register does not respond to any input without a Clk rising edge.
- All widths are exact WIDTH bits; no extension or truncation is needed.

Test Plan:
1. Reset: ResetB=1 for one edge with Q=4'b1011 and Load=1, D=4'b0110 -> Q=4'b0000 after that edge (reset overrides load).
2. Load: ResetB=0, Load=1, D=4'b1001 at one edge -> Q=4'b1001 after that edge. Q is unchanged before the edge even if D toggles.
3. Rotate: after loading 4'b0001, Load=0 for 4 edges -> Q sequence 4'b1000, 4'b0100, 4'b0010, 4'b0001 (returns to loaded value).
4. Rotate mixed pattern: load 4'b1101, then 2 edges with Load=0 -> 4'b1110, then 4'b0111. Popcount stays 3.
5. Consecutive loads: Load=1 for 3 edges with D = 4'b0011, 4'b0100, 4'b0101 -> Q follows D exactly, no rotation in between.
6. Reset mid-shift: load 4'b1010, rotate once (Q=4'b0101), then assert ResetB for one edge -> Q=4'b0000. Release with Load=0 -> Q stays 4'b0000. Load 4'b1111 -> Q=4'b1111.
